time_of_day_counter: RTL

Timekeeping core that consumes the 1 Hz square wave produced by the clock divider. It keeps hours, minutes and seconds as BCD digits for the display driver. It detects rising edges of the 1 Hz input inside the 100 MHz domain and carries seconds into minutes and minutes into hours. A set mode lets the user step hours and minutes with single-cycle button pulses; these pulses come from the debounce stage.

---
 rtl/time_of_day_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: BCD hh:mm:ss timekeeper advanced by 1 Hz rising edges, with hour/minute set mode
module time_of_day_counter #(
  parameter bit FORMAT_24H = 1'b1
) (
  input  logic       clk_100MHZ,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       sec_tick,
  output logic       rollover_day
);
  logic       clk_1hz_q, clk_1hz_d, armed_q, armed_d;
  logic [1:0] hour_tens_q, hour_tens_d;
  logic [3:0] hour_ones_q, hour_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       pm_q, pm_d, sec_tick_q, sec_tick_d, rollover_q, rollover_d;
  logic       tick, sec_wrap, min_wrap, min_inc, hour_inc;
  // armed blocks a tick from a clk_1Hz that is already high when reset releases
  always_comb begin
    clk_1hz_d   = clk_1Hz;
    armed_d     = armed_q | ~clk_1Hz;
    tick        = clk_1Hz & ~clk_1hz_q & armed_q;
    sec_wrap    = sec_tens_q == 3'd5 && sec_ones_q == 4'd9;
    min_wrap    = min_tens_q == 3'd5 && min_ones_q == 4'd9;
    min_inc     = set_mode ? inc_min : tick & sec_wrap;
    hour_inc    = set_mode ? inc_hour : tick & sec_wrap & min_wrap;
    sec_tick_d  = ~set_mode & tick;
    sec_ones_d  = set_mode ? 4'd0 : tick ? (sec_ones_q == 4'd9 ? 4'd0 : sec_ones_q + 4'd1) : sec_ones_q;
    sec_tens_d  = set_mode ? 3'd0 : (tick && sec_ones_q == 4'd9) ? (sec_tens_q == 3'd5 ? 3'd0 : sec_tens_q + 3'd1) : sec_tens_q;
    min_ones_d  = min_inc ? (min_ones_q == 4'd9 ? 4'd0 : min_ones_q + 4'd1) : min_ones_q;
    min_tens_d  = (min_inc && min_ones_q == 4'd9) ? (min_tens_q == 3'd5 ? 3'd0 : min_tens_q + 3'd1) : min_tens_q;
    hour_tens_d = hour_tens_q;
    hour_ones_d = hour_ones_q;
    pm_d        = pm_q;
    rollover_d  = 1'b0;
    if (hour_inc) begin
      if (FORMAT_24H) begin
        if (hour_tens_q == 2'd2 && hour_ones_q == 4'd3) begin
          hour_tens_d = 2'd0;
          hour_ones_d = 4'd0;
          rollover_d  = ~set_mode;
        end else if (hour_ones_q == 4'd9) begin
          hour_tens_d = hour_tens_q + 2'd1;
          hour_ones_d = 4'd0;
        end else
          hour_ones_d = hour_ones_q + 4'd1;
      end else begin
        if (hour_tens_q == 2'd1 && hour_ones_q == 4'd2) begin
          hour_tens_d = 2'd0;
          hour_ones_d = 4'd1;
        end else if (hour_tens_q == 2'd1 && hour_ones_q == 4'd1) begin
          hour_ones_d = 4'd2;
          pm_d        = ~pm_q;
          rollover_d  = ~set_mode & pm_q;
        end else if (hour_ones_q == 4'd9) begin
          hour_tens_d = 2'd1;
          hour_ones_d = 4'd0;
        end else
          hour_ones_d = hour_ones_q + 4'd1;
      end
    end
    if (FORMAT_24H) pm_d = hour_tens_d == 2'd2 || (hour_tens_d == 2'd1 && hour_ones_d >= 4'd2);
  end
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      clk_1hz_q   <= 1'b0;
      armed_q     <= 1'b0;
      hour_tens_q <= FORMAT_24H ? 2'd0 : 2'd1;
      hour_ones_q <= FORMAT_24H ? 4'd0 : 4'd2;
      min_tens_q  <= 3'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 3'd0;
      sec_ones_q  <= 4'd0;
      pm_q        <= 1'b0;
      sec_tick_q  <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      clk_1hz_q   <= clk_1hz_d;
      armed_q     <= armed_d;
      hour_tens_q <= hour_tens_d;
      hour_ones_q <= hour_ones_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      pm_q        <= pm_d;
      sec_tick_q  <= sec_tick_d;
      rollover_q  <= rollover_d;
    end
  end
  assign hour_tens    = hour_tens_q;
  assign hour_ones    = hour_ones_q;
  assign min_tens     = min_tens_q;
  assign min_ones     = min_ones_q;
  assign sec_tens     = sec_tens_q;
  assign sec_ones     = sec_ones_q;
  assign pm           = pm_q;
  assign sec_tick     = sec_tick_q;
  assign rollover_day = rollover_q;
endmodule
